self_ship_control: RTL
======================

// Module: self_ship_control
// PURPOSE
//   Control FSM sitting directly upstream of the player-ship datapath. Each
//   frame tick it samples the move/fire buttons, erases the 5x5 ship sprite,
//   loads the new clamped x, and redraws it. Drives the datapath's x_in,
//   op_in, enable and load, plus the VGA write strobe (plot). Emits a shot
//   pulse for the bullet logic.
// PARAMETERS
//   X_START      80      x loaded after reset
//   X_MIN        0       leftmost legal x
//   X_MAX        155     rightmost legal x (160 - sprite width 5)
//   STEP         1       pixels moved per frame tick
//   FRAME_TICKS  833333  clk cycles per frame tick (60 Hz @ 50 MHz), >= 2
// PORTS
//   clk       in   1  system clock, all logic on rising edge
//   reset     in   1  asynchronous, active-high reset
//   go_left   in   1  level, synchronous to clk; request move left
//   go_right  in   1  level, synchronous to clk; request move right
//   fire_btn  in   1  level, synchronous to clk; request fire
//   x_in      out  8  ship x to datapath; equals x_pos register
//   op_in     out  2  datapath op: 0 draw, 1 erase, 2 fire
//   enable    out  1  datapath pixel-counter advance
//   load      out  1  datapath x/y load strobe
//   plot      out  1  VGA write enable; high exactly when enable high
//   shot      out  1  1-cycle pulse: ship fired this frame
//   shot_x    out  8  x_pos + 2 (sprite centre column), valid with shot
//   busy      out  1  high in every state except WAIT
// BEHAVIOUR
//   Reset (async): state=LOAD, x_pos=X_START, pix_cnt=0, frame_cnt=0,
//     fire_r=0; outputs enable=0, load=0, plot=0, shot=0, op_in=1, busy=1.
//   States:
//   LOAD (1 cycle): load=1, enable=0, plot=0. Next: DRAW.
//   DRAW (25 cycles): enable=plot=1; op_in=2 if fire_r else 0;
//     pix_cnt counts 0..24. Exit at 24: pix_cnt<=0, -> WAIT.
//   WAIT: enable=plot=load=0, op_in=1, busy=0; frame_cnt counts
//     0..FRAME_TICKS-1. At terminal count: frame_cnt<=0, sample buttons.
//     - mv_l = go_left & ~go_right, mv_r = go_right & ~go_left (both
//       pressed = no move).
//     - If mv_l | mv_r | fire_btn: fire_r<=fire_btn; compute x_nxt; -> ERASE.
//     - Else stay in WAIT (no redraw, no bus activity).
//   ERASE (25 cycles): enable=plot=1, op_in=1; pix_cnt 0..24; at 24 ->
//     LOAD with x_pos<=x_nxt.
//   x_nxt arithmetic (9-bit, no wrap): left: max(x_pos-STEP, X_MIN);
//     right: min(x_pos+STEP, X_MAX); else x_pos. At a bound with move held
//     the cycle still runs (erase+redraw at same x).
//   shot: asserted the first DRAW cycle (pix_cnt==0) when fire_r=1, only if
//     entered from a button-triggered LOAD (not the post-reset LOAD).
//     fire_r clears on entering WAIT.
//   25 enables per phase leave datapath x/y counters at 0 on exit.
//   Buttons ignored outside the WAIT terminal cycle; no queuing.
//   Reset mid-ERASE/DRAW: abandons sprite immediately and restarts at LOAD
//     with X_START; partially drawn pixels are not cleaned up.
// TESTING (FRAME_TICKS=4 in bench)
//   Reset release -> LOAD 1 cycle (x_in=80, load=1), 25 cycles plot=1
//     op_in=0, then busy=0 in WAIT; shot never pulses.
//   Hold go_right one tick -> 25 erase cycles op_in=1, load with x_in=81,
//     25 draw cycles op_in=0; total 51 busy cycles.
//   x_pos=155, hold go_right -> erase/redraw at 155, x_in never 156;
//     x_pos=0, go_left -> stays 0.
//   go_left and go_right both held, no fire -> stays in WAIT, plot=0.
//   fire_btn at tick, x=80 -> draw op_in=2, shot=1 for 1 cycle, shot_x=82.
//   Assert reset in DRAW pix_cnt=10 -> outputs reset values same cycle;
//     after release, LOAD with x_in=80.

Source files
------------

// File: rtl/self_ship_control.sv
// Player-ship sequencer: once per frame tick it samples the buttons and, if
// anything was pressed, erases the 5x5 sprite, loads the new clamped x and
// redraws it. Drives the ship datapath and the VGA write strobe.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   LOAD   | one-cycle x/y load strobe into the datapath
//   DRAW   | 25 pixel writes of the sprite (op 0 draw, op 2 fire)
//   WAIT   | idle until frame tick; buttons sampled on the terminal cycle
//   ERASE  | 25 pixel writes erasing the sprite at the old x
module self_ship_control #(
    parameter int X_START     = 80,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 155,
    parameter int STEP        = 1,
    parameter int FRAME_TICKS = 833333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go_left,
    input  logic       go_right,
    input  logic       fire_btn,
    output logic [7:0] x_in,
    output logic [1:0] op_in,
    output logic       enable,
    output logic       load,
    output logic       plot,
    output logic       shot,
    output logic [7:0] shot_x,
    output logic       busy
);

    localparam int             FW         = $clog2(FRAME_TICKS);
    localparam logic [FW-1:0]  FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [4:0]     PIX_LAST   = 5'd24;
    localparam logic [8:0]     STEP9      = 9'(STEP);
    localparam logic [8:0]     MIN9       = 9'(X_MIN);
    localparam logic [8:0]     MAX9       = 9'(X_MAX);
    localparam logic [7:0]     X_MIN8     = 8'(X_MIN);
    localparam logic [7:0]     X_MAX8     = 8'(X_MAX);
    localparam logic [7:0]     X_START8   = 8'(X_START);

    localparam logic [1:0]     OP_DRAW    = 2'd0;
    localparam logic [1:0]     OP_ERASE   = 2'd1;
    localparam logic [1:0]     OP_FIRE    = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD,
        S_DRAW,
        S_WAIT,
        S_ERASE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      x_pos;
    logic [7:0]      x_nxt_r;
    logic [7:0]      x_nxt;
    logic [4:0]      pix_cnt;
    logic [FW-1:0]   frame_cnt;
    logic            fire_r;
    logic            load_i;

    logic            frame_tc;
    logic            pix_last;
    logic            mv_l;
    logic            mv_r;
    logic            trig;
    logic [8:0]      x_ext;

    assign frame_tc = (state == S_WAIT) && (frame_cnt == FRAME_LAST);
    assign pix_last = (pix_cnt == PIX_LAST);
    assign mv_l     = go_left & ~go_right;
    assign mv_r     = go_right & ~go_left;
    assign trig     = mv_l | mv_r | fire_btn;
    assign x_ext    = {1'b0, x_pos};

    // Next x, clamped in 9-bit arithmetic so neither edge can wrap
    always_comb begin
        x_nxt = x_pos;
        if (mv_l) begin
            x_nxt = (x_ext < MIN9 + STEP9) ? X_MIN8 : 8'(x_ext - STEP9);
        end else if (mv_r) begin
            x_nxt = (x_ext + STEP9 > MAX9) ? X_MAX8 : 8'(x_ext + STEP9);
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt = state;
        enable    = 1'b0;
        load_i    = 1'b0;
        op_in     = OP_ERASE;
        case (state)
            S_LOAD: begin
                load_i    = 1'b1;
                state_nxt = S_DRAW;
            end
            S_DRAW: begin
                enable = 1'b1;
                op_in  = fire_r ? OP_FIRE : OP_DRAW;
                if (pix_last) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (frame_tc && trig) begin
                    state_nxt = S_ERASE;
                end
            end
            S_ERASE: begin
                enable = 1'b1;
                if (pix_last) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Load is masked while reset is held so the datapath sees no strobe
    // until the post-reset LOAD cycle actually runs.
    assign load   = load_i & ~reset;
    assign plot   = enable;
    assign busy   = (state != S_WAIT);
    assign shot   = (state == S_DRAW) && (pix_cnt == 5'd0) && fire_r;
    assign x_in   = x_pos;
    assign shot_x = x_pos + 8'd2;

    // Pixel counter: 25 enables per sprite pass, back at 0 on exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt <= 5'd0;
        end else if ((state == S_DRAW) || (state == S_ERASE)) begin
            pix_cnt <= pix_last ? 5'd0 : pix_cnt + 5'd1;
        end else begin
            pix_cnt <= 5'd0;
        end
    end

    // Frame-tick timer, only runs while idle in WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (state == S_WAIT) begin
            frame_cnt <= frame_tc ? '0 : frame_cnt + 1'b1;
        end else begin
            frame_cnt <= '0;
        end
    end

    // Ship position and fire latch; x commits at the end of the erase pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_pos   <= X_START8;
            x_nxt_r <= X_START8;
            fire_r  <= 1'b0;
        end else begin
            if (frame_tc && trig) begin
                fire_r  <= fire_btn;
                x_nxt_r <= x_nxt;
            end else if ((state == S_DRAW) && pix_last) begin
                fire_r  <= 1'b0;
            end
            if ((state == S_ERASE) && pix_last) begin
                x_pos <= x_nxt_r;
            end
        end
    end

endmodule
